wt_dcache_rd_arbiter: RTL and testbench

// Parametrised N-port arbiter in front of the write-through dcache SRAM banks (single-ported).

---
 rtl/wt_cache_pkg.sv | 25 ++
 rtl/wt_dcache_rr_pick.sv | 29 ++
 rtl/wt_dcache_rd_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wt_dcache_rd_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache types and geometry used by the SRAM read arbiter.
package wt_cache_pkg;

  localparam int unsigned DCACHE_CL_IDX_WIDTH     = 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH     = 4;
  localparam int unsigned DCACHE_TAG_WIDTH        = 12;
  localparam int unsigned DCACHE_RD_ARB_MAX_PORTS = 8;

  typedef struct packed {
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] off;
    logic [DCACHE_TAG_WIDTH-1:0]    tag;
    logic                           tag_only;
  } rd_arb_port_t;

  // Port index width, never narrower than one bit so a single-port arbiter still has a field.
  function automatic int unsigned rd_arb_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rd_arb_cnt_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// Round-robin picker: first set bit of mask at or after ptr, wrapping modulo NumPorts.
module wt_dcache_rr_pick import wt_cache_pkg::*; #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned IdxWidth = rd_arb_idx_width(NumPorts)
) (
  input  logic [NumPorts-1:0] mask_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                vld_o
);

  always_comb begin
    logic [IdxWidth-1:0] pos;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      pos = IdxWidth'((32'(ptr_i) + i) % NumPorts);
      if (!vld_o && mask_i[pos]) begin
        vld_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/wt_dcache_rd_arbiter.sv
// Single-ported dcache SRAM arbiter: refill lockout, starvation override, two RR priority
// classes for the read ports, a word-write port, and a one-cycle registered read response.
module wt_dcache_rd_arbiter import wt_cache_pkg::*; #(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned StarveLimit = 8,
  parameter int unsigned CntWidth    = rd_arb_cnt_width(StarveLimit)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumPorts-1:0]                       rd_req_i,
  input  logic [NumPorts-1:0]                       rd_prio_i,
  input  logic [NumPorts-1:0]                       rd_tag_only_i,
  input  logic [NumPorts*DCACHE_CL_IDX_WIDTH-1:0]   rd_idx_i,
  input  logic [NumPorts*DCACHE_OFFSET_WIDTH-1:0]   rd_off_i,
  input  logic [NumPorts*DCACHE_TAG_WIDTH-1:0]      rd_tag_i,
  output logic [NumPorts-1:0]                       rd_ack_o,
  input  logic                                      wr_req_i,
  output logic                                      wr_ack_o,
  input  logic                                      wr_cl_vld_i,
  output logic                                      bank_req_o,
  output logic                                      bank_we_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]            bank_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]            bank_off_o,
  output logic                                      bank_tag_only_o,
  output logic                                      rsp_vld_o,
  output logic [rd_arb_idx_width(NumPorts)-1:0]     rsp_port_o,
  output logic [DCACHE_TAG_WIDTH-1:0]               rsp_tag_o
);

  localparam int unsigned         IdxWidth = rd_arb_idx_width(NumPorts);
  localparam bit                  StarveEn = (StarveLimit > 0);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(StarveLimit);
  localparam logic [IdxWidth-1:0] LastPort = IdxWidth'(NumPorts - 1);

  rd_arb_port_t        ports [NumPorts];
  rd_arb_port_t        sel_port;
  logic [CntWidth-1:0] rd_cnt_q [NumPorts];
  logic [CntWidth-1:0] wr_cnt_q;
  logic [IdxWidth-1:0] hi_ptr_q, lo_ptr_q, nxt_ptr;
  logic [NumPorts-1:0] starve_mask, hi_mask, lo_mask;
  logic [NumPorts-1:0] starve_gnt, hi_gnt, lo_gnt;
  logic [IdxWidth-1:0] starve_idx, hi_idx, lo_idx, gnt_idx;
  logic                starve_vld, hi_vld, lo_vld, gnt_vld, gnt_hi, wr_starve;

  for (genvar g = 0; g < NumPorts; g++) begin : g_unpack
    assign ports[g] = '{
      idx:      rd_idx_i[g*DCACHE_CL_IDX_WIDTH +: DCACHE_CL_IDX_WIDTH],
      off:      rd_off_i[g*DCACHE_OFFSET_WIDTH +: DCACHE_OFFSET_WIDTH],
      tag:      rd_tag_i[g*DCACHE_TAG_WIDTH +: DCACHE_TAG_WIDTH],
      tag_only: rd_tag_only_i[g]
    };
  end

  always_comb begin
    starve_mask = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      starve_mask[i] = StarveEn && rd_req_i[i] && (rd_cnt_q[i] == CntMax);
    end
  end

  assign wr_starve = StarveEn && wr_req_i && (wr_cnt_q == CntMax);
  assign hi_mask   = rd_req_i & rd_prio_i;
  assign lo_mask   = rd_req_i & ~rd_prio_i;

  // Starved ports share the low-class pointer so the override rotates independently of class.
  wt_dcache_rr_pick #(.NumPorts(NumPorts), .IdxWidth(IdxWidth)) i_pick_starve (
    .mask_i (starve_mask),
    .ptr_i  (lo_ptr_q),
    .gnt_o  (starve_gnt),
    .idx_o  (starve_idx),
    .vld_o  (starve_vld)
  );

  wt_dcache_rr_pick #(.NumPorts(NumPorts), .IdxWidth(IdxWidth)) i_pick_hi (
    .mask_i (hi_mask),
    .ptr_i  (hi_ptr_q),
    .gnt_o  (hi_gnt),
    .idx_o  (hi_idx),
    .vld_o  (hi_vld)
  );

  wt_dcache_rr_pick #(.NumPorts(NumPorts), .IdxWidth(IdxWidth)) i_pick_lo (
    .mask_i (lo_mask),
    .ptr_i  (lo_ptr_q),
    .gnt_o  (lo_gnt),
    .idx_o  (lo_idx),
    .vld_o  (lo_vld)
  );

  always_comb begin
    rd_ack_o = '0;
    wr_ack_o = 1'b0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    if (!wr_cl_vld_i) begin
      if (wr_starve) begin
        wr_ack_o = 1'b1;
      end else if (starve_vld) begin
        rd_ack_o = starve_gnt;
        gnt_idx  = starve_idx;
        gnt_vld  = 1'b1;
      end else if (hi_vld) begin
        rd_ack_o = hi_gnt;
        gnt_idx  = hi_idx;
        gnt_vld  = 1'b1;
      end else if (lo_vld) begin
        rd_ack_o = lo_gnt;
        gnt_idx  = lo_idx;
        gnt_vld  = 1'b1;
      end
      if (!gnt_vld && wr_req_i) begin
        wr_ack_o = 1'b1;
      end
    end
  end

  // One-hot ack selects the request fields; idle and write cycles present zeros to the banks.
  always_comb begin
    sel_port = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (rd_ack_o[i]) begin
        sel_port = ports[i];
      end
    end
  end

  assign gnt_hi          = |(rd_ack_o & rd_prio_i);
  assign nxt_ptr         = (gnt_idx == LastPort) ? '0 : gnt_idx + 1'b1;
  assign bank_req_o      = (|rd_ack_o) | wr_ack_o;
  assign bank_we_o       = wr_ack_o;
  assign bank_idx_o      = sel_port.idx;
  assign bank_off_o      = sel_port.off;
  assign bank_tag_only_o = sel_port.tag_only;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_ptr_q <= '0;
      lo_ptr_q <= '0;
    end else if (gnt_vld) begin
      if (gnt_hi) begin
        hi_ptr_q <= nxt_ptr;
      end else begin
        lo_ptr_q <= nxt_ptr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        rd_cnt_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (rd_ack_o[i] || !rd_req_i[i] || !StarveEn) begin
          rd_cnt_q[i] <= '0;
        end else if (rd_cnt_q[i] != CntMax) begin
          rd_cnt_q[i] <= rd_cnt_q[i] + 1'b1;
        end
      end
      if (wr_ack_o || !wr_req_i || !StarveEn) begin
        wr_cnt_q <= '0;
      end else if (wr_cnt_q != CntMax) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  // Response trails the grant by one cycle to line up with the SRAM read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_o  <= 1'b0;
      rsp_port_o <= '0;
      rsp_tag_o  <= '0;
    end else begin
      rsp_vld_o <= gnt_vld;
      if (gnt_vld) begin
        rsp_port_o <= gnt_idx;
        rsp_tag_o  <= sel_port.tag;
      end
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_arbiter.sv
// Self-checking bench: two arbiters (StarveLimit 2 and 0) on shared stimulus, checked by a
// port-level reference model, a directed vector table and hand-written corner sequences.
module tb_wt_dcache_rd_arbiter;
  import wt_cache_pkg::*;

  localparam int N = 3;

  logic        clk, rst_n;
  logic [N-1:0] rd_req, rd_prio, rd_tag_only;
  logic [DCACHE_CL_IDX_WIDTH-1:0] idx_a [N];
  logic [DCACHE_OFFSET_WIDTH-1:0] off_a [N];
  logic [DCACHE_TAG_WIDTH-1:0]    tag_a [N];
  logic        wr_req, cl_vld;

  logic [N*DCACHE_CL_IDX_WIDTH-1:0] idx_flat;
  logic [N*DCACHE_OFFSET_WIDTH-1:0] off_flat;
  logic [N*DCACHE_TAG_WIDTH-1:0]    tag_flat;
  assign idx_flat = {idx_a[2], idx_a[1], idx_a[0]};
  assign off_flat = {off_a[2], off_a[1], off_a[0]};
  assign tag_flat = {tag_a[2], tag_a[1], tag_a[0]};

  logic [N-1:0]                   ack   [2];
  logic                           wack  [2];
  logic                           breq  [2];
  logic                           bwe   [2];
  logic [DCACHE_CL_IDX_WIDTH-1:0] bidx  [2];
  logic [DCACHE_OFFSET_WIDTH-1:0] boff  [2];
  logic                           bto   [2];
  logic                           rvld  [2];
  logic [1:0]                     rport [2];
  logic [DCACHE_TAG_WIDTH-1:0]    rtag  [2];

  wt_dcache_rd_arbiter #(.NumPorts(N), .StarveLimit(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_req_i(rd_req), .rd_prio_i(rd_prio),
    .rd_tag_only_i(rd_tag_only), .rd_idx_i(idx_flat), .rd_off_i(off_flat), .rd_tag_i(tag_flat),
    .rd_ack_o(ack[0]), .wr_req_i(wr_req), .wr_ack_o(wack[0]), .wr_cl_vld_i(cl_vld),
    .bank_req_o(breq[0]), .bank_we_o(bwe[0]), .bank_idx_o(bidx[0]), .bank_off_o(boff[0]),
    .bank_tag_only_o(bto[0]), .rsp_vld_o(rvld[0]), .rsp_port_o(rport[0]), .rsp_tag_o(rtag[0])
  );

  wt_dcache_rd_arbiter #(.NumPorts(N), .StarveLimit(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rd_req_i(rd_req), .rd_prio_i(rd_prio),
    .rd_tag_only_i(rd_tag_only), .rd_idx_i(idx_flat), .rd_off_i(off_flat), .rd_tag_i(tag_flat),
    .rd_ack_o(ack[1]), .wr_req_i(wr_req), .wr_ack_o(wack[1]), .wr_cl_vld_i(cl_vld),
    .bank_req_o(breq[1]), .bank_we_o(bwe[1]), .bank_idx_o(bidx[1]), .bank_off_o(boff[1]),
    .bank_tag_only_o(bto[1]), .rsp_vld_o(rvld[1]), .rsp_port_o(rport[1]), .rsp_tag_o(rtag[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state, one slot per DUT instance.
  int lim [2] = '{2, 0};
  int m_cnt [2][N];
  int m_wcnt [2];
  int m_hptr [2];
  int m_lptr [2];
  bit m_rvld [2];
  int m_rport [2];
  int m_rtag [2];

  typedef struct {
    logic [2:0] req;
    logic [2:0] prio;
    logic       wr;
    logic       cl;
    logic [2:0] ack2;
    logic       wack2;
    logic [2:0] ack0;
    logic       wack0;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < N; p++) m_cnt[k][p] = 0;
      m_wcnt[k] = 0; m_hptr[k] = 0; m_lptr[k] = 0;
      m_rvld[k] = 0; m_rport[k] = 0; m_rtag[k] = 0;
    end
  endtask

  function automatic int pick(input logic [2:0] m, input int ptr);
    for (int i = 0; i < N; i++) begin
      int p;
      p = (ptr + i) % N;
      if (m[p]) return p;
    end
    return -1;
  endfunction

  // Compare both DUTs against the model for the current inputs, then advance the model.
  task automatic modelCheck();
    for (int k = 0; k < 2; k++) begin
      int g;
      bit w;
      logic [2:0] sm;
      g = -1; w = 0; sm = '0;
      if (!cl_vld) begin
        if (lim[k] > 0 && wr_req && m_wcnt[k] == lim[k]) w = 1;
        else begin
          for (int p = 0; p < N; p++) sm[p] = (lim[k] > 0) && rd_req[p] && (m_cnt[k][p] == lim[k]);
          g = pick(sm, m_lptr[k]);
          if (g < 0) g = pick(rd_req & rd_prio, m_hptr[k]);
          if (g < 0) g = pick(rd_req & ~rd_prio, m_lptr[k]);
        end
        if (g < 0 && wr_req) w = 1;
      end
      checkOutput("rd_ack", k, 32'(ack[k]), (g >= 0) ? (32'd1 << g) : 32'd0);
      checkOutput("wr_ack", k, 32'(wack[k]), 32'(w));
      checkOutput("bank_req", k, 32'(breq[k]), 32'((g >= 0) || w));
      checkOutput("bank_we", k, 32'(bwe[k]), 32'(w));
      checkOutput("bank_idx", k, 32'(bidx[k]), (g >= 0) ? 32'(idx_a[g]) : 32'd0);
      checkOutput("bank_off", k, 32'(boff[k]), (g >= 0) ? 32'(off_a[g]) : 32'd0);
      checkOutput("bank_tag_only", k, 32'(bto[k]), (g >= 0) ? 32'(rd_tag_only[g]) : 32'd0);
      checkOutput("rsp_vld", k, 32'(rvld[k]), 32'(m_rvld[k]));
      checkOutput("rsp_port", k, 32'(rport[k]), 32'(m_rport[k]));
      checkOutput("rsp_tag", k, 32'(rtag[k]), 32'(m_rtag[k]));
      for (int p = 0; p < N; p++) begin
        if (g == p || !rd_req[p] || lim[k] == 0) m_cnt[k][p] = 0;
        else if (m_cnt[k][p] < lim[k]) m_cnt[k][p]++;
      end
      if (w || !wr_req || lim[k] == 0) m_wcnt[k] = 0;
      else if (m_wcnt[k] < lim[k]) m_wcnt[k]++;
      m_rvld[k] = (g >= 0);
      if (g >= 0) begin
        if (rd_prio[g]) m_hptr[k] = (g + 1) % N;
        else m_lptr[k] = (g + 1) % N;
        m_rport[k] = g;
        m_rtag[k] = int'(tag_a[g]);
      end
    end
  endtask

  task automatic applyStimulus();
    #4;
    modelCheck();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [2:0] req, input logic [2:0] prio, input logic wr,
                        input logic cl, input logic [2:0] a2, input logic w2,
                        input logic [2:0] a0, input logic w0);
    vec_t v;
    v = '{req, prio, wr, cl, a2, w2, a0, w0};
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; rd_req = '0; rd_prio = '0; rd_tag_only = '0; wr_req = 0; cl_vld = 0;
    for (int p = 0; p < N; p++) begin
      idx_a[p] = 8'(8'h10 + p); off_a[p] = 4'(p + 3); tag_a[p] = 12'(12'h100 + p);
    end
    modelReset();

    // Round robin within the high class, then starvation override for low port 2.
    for (int c = 0; c < 3; c++) addVec(3'b111, 3'b011, 0, 0,
                                       (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : 3'b100, 0,
                                       (c == 1) ? 3'b010 : 3'b001, 0);
    addVec(3'b000, 3'b011, 0, 0, 3'b000, 0, 3'b000, 0);
    // Refill lockout lets every counter saturate; release hits the starve picker at low ptr 0.
    for (int c = 0; c < 3; c++) addVec(3'b111, 3'b011, 0, 1, 3'b000, 0, 3'b000, 0);
    addVec(3'b111, 3'b011, 0, 0, 3'b001, 0, 3'b010, 0);
    addVec(3'b000, 3'b011, 0, 0, 3'b000, 0, 3'b000, 0);
    // Write held against a continuous high-class reader.
    addVec(3'b001, 3'b011, 1, 0, 3'b001, 0, 3'b001, 0);
    addVec(3'b001, 3'b011, 1, 0, 3'b001, 0, 3'b001, 0);
    addVec(3'b001, 3'b011, 1, 0, 3'b000, 1, 3'b001, 0);
    addVec(3'b001, 3'b011, 1, 0, 3'b001, 0, 3'b001, 0);
    addVec(3'b000, 3'b011, 0, 0, 3'b000, 0, 3'b000, 0);

    #2;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_rsp_vld", k, 32'(rvld[k]), 0);
      checkOutput("reset_rsp_port", k, 32'(rport[k]), 0);
      checkOutput("reset_rsp_tag", k, 32'(rtag[k]), 0);
      checkOutput("reset_bank_req", k, 32'(breq[k]), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      rd_req = vecs[i].req; rd_prio = vecs[i].prio; wr_req = vecs[i].wr; cl_vld = vecs[i].cl;
      applyStimulus();
      checkOutput($sformatf("vec%0d_rd_ack", i), 0, 32'(ack[0]), 32'(vecs[i].ack2));
      checkOutput($sformatf("vec%0d_wr_ack", i), 0, 32'(wack[0]), 32'(vecs[i].wack2));
      checkOutput($sformatf("vec%0d_rd_ack", i), 1, 32'(ack[1]), 32'(vecs[i].ack0));
      checkOutput($sformatf("vec%0d_wr_ack", i), 1, 32'(wack[1]), 32'(vecs[i].wack0));
      advance();
    end

    // Single read on port 0: bank access now, tagged response next cycle.
    tag_a[0] = 12'h1A5;
    rd_req = 3'b001; wr_req = 0; cl_vld = 0;
    applyStimulus();
    for (int k = 0; k < 2; k++) checkOutput("single_bank_req", k, 32'(breq[k]), 1);
    advance();
    rd_req = 3'b000;
    applyStimulus();
    for (int k = 0; k < 2; k++) begin
      checkOutput("single_rsp_vld", k, 32'(rvld[k]), 1);
      checkOutput("single_rsp_port", k, 32'(rport[k]), 0);
      checkOutput("single_rsp_tag", k, 32'(rtag[k]), 32'h1A5);
    end
    advance();

    rd_prio = 3'($urandom);
    for (int c = 0; c < 400; c++) begin
      rd_req = 3'($urandom);
      rd_tag_only = 3'($urandom);
      wr_req = 1'($urandom_range(0, 1));
      cl_vld = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < N; p++) begin
        idx_a[p] = 8'($urandom); off_a[p] = 4'($urandom); tag_a[p] = 12'($urandom);
      end
      applyStimulus();
      advance();
    end

    // Grant port 1, then reset while its response is pending.
    rd_req = 3'b010; rd_prio = 3'b111; wr_req = 0; cl_vld = 0;
    applyStimulus();
    advance();
    rst_n = 1'b0;
    modelReset();
    #1;
    for (int k = 0; k < 2; k++) checkOutput("midreset_rsp_vld", k, 32'(rvld[k]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_req = 3'b111;
    applyStimulus();
    for (int k = 0; k < 2; k++) checkOutput("post_reset_ack", k, 32'(ack[k]), 32'b001);
    advance();
    rd_req = 3'b000;
    applyStimulus();
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
